calc_cmd_scheduler: RTL and testbench

Command scheduler that sits in front of the calculator core and feeds its 4-bit `cmd` input. Two requesters, keypad (port 0) and host/script (port 1), push command codes into a shared FIFO through a round-robin arbiter. An issue FSM drains the FIFO one command at a time, only when the core reports ready (`calc_status == 2'b10`), and waits for the core to go busy and return ready before issuing the next command. Core error (`2'b00`) or a handshake timeout flushes the queue and latches `err` until reset.

---
 rtl/calc_cmd_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_calc_cmd_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_scheduler.sv
// Command scheduler in front of the calculator core: a two-port round-robin arbiter
// feeds a FIFO, and an issue FSM drains it one command per core ready/busy/ready cycle.
module calc_cmd_scheduler #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [3:0]  IDLE_CMD = 4'b1101
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   req0_valid_i,
  input  logic [3:0]             req0_cmd_i,
  output logic                   req0_ready_o,
  input  logic                   req1_valid_i,
  input  logic [3:0]             req1_cmd_i,
  output logic                   req1_ready_o,
  input  logic [1:0]             calc_status_i,
  output logic [3:0]             cmd_o,
  output logic                   cmd_valid_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   busy_o,
  output logic                   err_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_CNT  = TW'(TIMEOUT);
  localparam logic [1:0] ST_ERR  = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_RDY  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_READY = 2'd2,
    S_ERROR      = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc_s;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [3:0]    mem_q [DEPTH];
  logic          last_q;
  logic          full_s, empty_s, err_s;
  logic          grant0_s, grant1_s, push_s, pop_s, err_entry_s;
  logic [3:0]    push_cmd_s;

  // Arbitration and push handshake; last_q == 1 means port 1 was served last.
  always_comb begin
    full_s       = (count_q == FULL_CNT);
    empty_s      = (count_q == {CW{1'b0}});
    err_s        = (state_q == S_ERROR);
    grant0_s     = req0_valid_i & (~req1_valid_i | last_q);
    grant1_s     = req1_valid_i & (~req0_valid_i | ~last_q);
    req0_ready_o = grant0_s & ~full_s & ~err_s & ~reset_i;
    req1_ready_o = grant1_s & ~full_s & ~err_s & ~reset_i;
    push_cmd_s   = grant1_s ? req1_cmd_i : req0_cmd_i;
    push_s       = ((req0_ready_o & req0_valid_i) | (req1_ready_o & req1_valid_i)) & ~err_entry_s;
  end

  // Issue FSM next-state, registered command outputs and handshake timer.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    timer_d     = timer_q;
    pop_s       = 1'b0;
    err_entry_s = 1'b0;
    timer_inc_s = (timer_q == TMO_CNT) ? timer_q : timer_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        cmd_d       = IDLE_CMD;
        cmd_valid_d = 1'b0;
        if (calc_status_i == ST_ERR) begin
          err_entry_s = 1'b1;
        end else if (!empty_s && calc_status_i == ST_RDY) begin
          pop_s       = 1'b1;
          cmd_d       = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          timer_d     = {TW{1'b0}};
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (calc_status_i == ST_ERR) begin
          err_entry_s = 1'b1;
        end else if (calc_status_i == ST_BUSY) begin
          cmd_d       = IDLE_CMD;
          cmd_valid_d = 1'b0;
          timer_d     = {TW{1'b0}};
          state_d     = S_WAIT_READY;
        end else if (timer_inc_s == TMO_CNT) begin
          err_entry_s = 1'b1;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      S_WAIT_READY: begin
        cmd_d       = IDLE_CMD;
        cmd_valid_d = 1'b0;
        if (calc_status_i == ST_ERR) begin
          err_entry_s = 1'b1;
        end else if (calc_status_i == ST_RDY) begin
          state_d = S_IDLE;
        end else if (timer_inc_s == TMO_CNT) begin
          err_entry_s = 1'b1;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      S_ERROR: begin
        cmd_d       = IDLE_CMD;
        cmd_valid_d = 1'b0;
      end
      default: begin
        err_entry_s = 1'b1;
      end
    endcase
    // Error entry wins over any pop or state advance in the same cycle.
    if (err_entry_s) begin
      state_d     = S_ERROR;
      cmd_d       = IDLE_CMD;
      cmd_valid_d = 1'b0;
      timer_d     = {TW{1'b0}};
      pop_s       = 1'b0;
    end else begin
      timer_d = timer_d;
    end
  end

  // FSM state, command output and timer registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cmd_q       <= IDLE_CMD;
      cmd_valid_q <= 1'b0;
      timer_q     <= {TW{1'b0}};
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      timer_q     <= timer_d;
    end
  end

  // FIFO pointers and occupancy; error entry flushes.
  always_ff @(posedge clock_i) begin
    if (reset_i || err_entry_s) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clock_i) begin
    if (push_s) mem_q[wr_ptr_q] <= push_cmd_s;
  end

  // Round-robin history, updated only on an accepted push.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
    end else if (push_s) begin
      last_q <= grant1_s;
    end
  end

  assign cmd_o        = cmd_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != S_IDLE) | ~empty_s;
  assign err_o        = err_s;
endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Directed self-checking bench for calc_cmd_scheduler; a second instance with
// TIMEOUT = 4 covers the handshake timeout.
module tb_calc_cmd_scheduler;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, r0v, r1v, r0r, r1r, cmd_valid, busy, err;
  logic [3:0] r0c, r1c, cmd, cnt;
  logic [1:0] status;
  logic       reset_b, r0v_b, r1v_b, r0r_b, r1r_b, cmd_valid_b, busy_b, err_b;
  logic [3:0] r0c_b, r1c_b, cmd_b, cnt_b;
  logic [1:0] status_b;

  int errors = 0;
  int checks = 0;

  calc_cmd_scheduler u_dut (
    .clock_i(clock), .reset_i(reset),
    .req0_valid_i(r0v), .req0_cmd_i(r0c), .req0_ready_o(r0r),
    .req1_valid_i(r1v), .req1_cmd_i(r1c), .req1_ready_o(r1r),
    .calc_status_i(status), .cmd_o(cmd), .cmd_valid_o(cmd_valid),
    .fifo_count_o(cnt), .busy_o(busy), .err_o(err)
  );

  calc_cmd_scheduler #(.TIMEOUT(4)) u_dut_to (
    .clock_i(clock), .reset_i(reset_b),
    .req0_valid_i(r0v_b), .req0_cmd_i(r0c_b), .req0_ready_o(r0r_b),
    .req1_valid_i(r1v_b), .req1_cmd_i(r1c_b), .req1_ready_o(r1r_b),
    .calc_status_i(status_b), .cmd_o(cmd_b), .cmd_valid_o(cmd_valid_b),
    .fifo_count_o(cnt_b), .busy_o(busy_b), .err_o(err_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    r0v    = 1'b0;
    r1v    = 1'b0;
    status = 2'b10;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Plays the core: waits for an issued command, checks it, then busy for one cycle and ready.
  task automatic issue_one(input string tag, input logic [3:0] exp);
    int k = 0;
    while (cmd_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd1);
    chk(tag, {28'd0, cmd}, {28'd0, exp});
    status = 2'b01;
    tick();
    status = 2'b10;
    tick();
  endtask

  logic [3:0] p0 [3] = '{4'd1, 4'd2, 4'd3};
  logic [3:0] p1 [3] = '{4'd7, 4'd8, 4'd9};
  logic [3:0] arb_order [6] = '{4'd1, 4'd7, 4'd2, 4'd8, 4'd3, 4'd9};
  int idx0, idx1;

  initial begin
    reset = 1'b1; r0v = 1'b1; r0c = 4'd0; r1v = 1'b0; r1c = 4'd0; status = 2'b10;
    reset_b = 1'b1; r0v_b = 1'b0; r0c_b = 4'd0; r1v_b = 1'b0; r1c_b = 4'd0; status_b = 2'b10;
    #1;
    chk("rst_ready0", {31'd0, r0r}, 32'd0);
    tick();
    tick();
    chk("rst_cmd", {28'd0, cmd}, 32'hD);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_count", {28'd0, cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Single command: two cycles from handshake to cmd_valid.
    reset = 1'b0; r0c = 4'd5;
    #1;
    chk("s_ready0", {31'd0, r0r}, 32'd1);
    tick();
    r0v = 1'b0;
    chk("s_count1", {28'd0, cnt}, 32'd1);
    chk("s_busy1", {31'd0, busy}, 32'd1);
    chk("s_valid_early", {31'd0, cmd_valid}, 32'd0);
    tick();
    chk("s_valid", {31'd0, cmd_valid}, 32'd1);
    chk("s_cmd", {28'd0, cmd}, 32'd5);
    chk("s_count0", {28'd0, cnt}, 32'd0);
    status = 2'b01;
    tick();
    chk("s_wait_cmd", {28'd0, cmd}, 32'hD);
    chk("s_wait_valid", {31'd0, cmd_valid}, 32'd0);
    tick();
    tick();
    chk("s_wait_busy", {31'd0, busy}, 32'd1);
    status = 2'b10;
    tick();
    chk("s_done_busy", {31'd0, busy}, 32'd0);
    chk("s_done_cmd", {28'd0, cmd}, 32'hD);

    // Arbitration: both ports valid, port 0 wins the first tie after reset.
    do_reset();
    status = 2'b01;
    idx0 = 0;
    idx1 = 0;
    for (int i = 0; i < 6; i++) begin
      r0v = (idx0 < 3);
      r1v = (idx1 < 3);
      r0c = (idx0 < 3) ? p0[idx0] : 4'd0;
      r1c = (idx1 < 3) ? p1[idx1] : 4'd0;
      #1;
      chk("arb_ready0", {31'd0, r0r}, {31'd0, (i % 2 == 0)});
      chk("arb_ready1", {31'd0, r1r}, {31'd0, (i % 2 == 1)});
      tick();
      if (i % 2 == 0) idx0++; else idx1++;
    end
    r0v = 1'b0;
    r1v = 1'b0;
    chk("arb_count", {28'd0, cnt}, 32'd6);
    status = 2'b10;
    for (int i = 0; i < 6; i++) issue_one("arb_issue", arb_order[i]);
    chk("arb_busy", {31'd0, busy}, 32'd0);

    // Full FIFO, then drain across pointer wrap.
    status = 2'b01;
    for (int i = 0; i < 8; i++) begin
      r0v = 1'b1;
      r0c = 4'(i + 1);
      tick();
    end
    chk("full_count", {28'd0, cnt}, 32'd8);
    r1v = 1'b1;
    #1;
    chk("full_ready0", {31'd0, r0r}, 32'd0);
    chk("full_ready1", {31'd0, r1r}, 32'd0);
    tick();
    chk("full_hold", {28'd0, cnt}, 32'd8);
    r0v = 1'b0;
    r1v = 1'b0;
    status = 2'b10;
    for (int i = 0; i < 8; i++) issue_one("full_issue", 4'(i + 1));
    status = 2'b01;
    for (int i = 0; i < 8; i++) begin
      r0v = 1'b1;
      r0c = 4'(15 - i);
      tick();
    end
    r0v = 1'b0;
    chk("wrap_count", {28'd0, cnt}, 32'd8);
    status = 2'b10;
    for (int i = 0; i < 8; i++) issue_one("wrap_issue", 4'(15 - i));

    // Simultaneous push and pop leaves the count unchanged.
    status = 2'b01;
    for (int i = 0; i < 3; i++) begin
      r0v = 1'b1;
      r0c = 4'(i + 3);
      tick();
    end
    r0v = 1'b0;
    chk("pp_count_pre", {28'd0, cnt}, 32'd3);
    status = 2'b10;
    r1v = 1'b1;
    r1c = 4'hE;
    #1;
    chk("pp_ready1", {31'd0, r1r}, 32'd1);
    tick();
    r1v = 1'b0;
    chk("pp_count", {28'd0, cnt}, 32'd3);
    chk("pp_valid", {31'd0, cmd_valid}, 32'd1);
    chk("pp_cmd", {28'd0, cmd}, 32'd3);

    // Core error mid-queue: flush, sticky err, push in the entry cycle discarded.
    r0v = 1'b1;
    r0c = 4'h6;
    status = 2'b01;
    tick();
    r0v = 1'b0;
    chk("e_count4", {28'd0, cnt}, 32'd4);
    chk("e_wait_cmd", {28'd0, cmd}, 32'hD);
    status = 2'b00;
    r0v = 1'b1;
    r0c = 4'h7;
    #1;
    chk("e_entry_ready0", {31'd0, r0r}, 32'd1);
    tick();
    chk("e_err", {31'd0, err}, 32'd1);
    chk("e_count0", {28'd0, cnt}, 32'd0);
    chk("e_cmd", {28'd0, cmd}, 32'hD);
    chk("e_valid", {31'd0, cmd_valid}, 32'd0);
    r1v = 1'b1;
    #1;
    chk("e_ready0", {31'd0, r0r}, 32'd0);
    chk("e_ready1", {31'd0, r1r}, 32'd0);
    status = 2'b10;
    tick();
    tick();
    chk("e_sticky", {31'd0, err}, 32'd1);
    chk("e_held_empty", {28'd0, cnt}, 32'd0);
    reset = 1'b1;
    #1;
    chk("e_rst_ready0", {31'd0, r0r}, 32'd0);
    tick();
    reset = 1'b0;
    r0v = 1'b0;
    r1v = 1'b0;
    #1;
    chk("e_rst_err", {31'd0, err}, 32'd0);
    chk("e_rst_cmd", {28'd0, cmd}, 32'hD);
    chk("e_rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("e_rst_count", {28'd0, cnt}, 32'd0);
    chk("e_rst_busy", {31'd0, busy}, 32'd0);

    // Timeout with TIMEOUT = 4: status stuck at ready after issue.
    tick();
    reset_b = 1'b0;
    r0v_b = 1'b1;
    r0c_b = 4'd6;
    tick();
    r0v_b = 1'b0;
    tick();
    chk("to_valid", {31'd0, cmd_valid_b}, 32'd1);
    chk("to_cmd", {28'd0, cmd_b}, 32'd6);
    tick();
    tick();
    tick();
    chk("to_err_early", {31'd0, err_b}, 32'd0);
    chk("to_still_issue", {31'd0, cmd_valid_b}, 32'd1);
    tick();
    chk("to_err", {31'd0, err_b}, 32'd1);
    chk("to_cmd_idle", {28'd0, cmd_b}, 32'hD);
    chk("to_valid_low", {31'd0, cmd_valid_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
